// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives a req/ready instruction memory, issues one instruction to decode.
// Optional macro DELAY_SLOT_EN selects MIPS branch-delay-slot redirect semantics.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        branch,
   input  logic        branch_taken,
   input  logic [15:0] branch_imm,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   output logic [31:0] pc
);

   typedef enum logic [1:0] {
      S_BOOT,
      S_FETCH,
      S_ISSUE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_valid_q, inst_valid_d;
   logic        flush_pending_q, flush_pending_d;
   logic [31:0] flush_target_q, flush_target_d;
`ifdef DELAY_SLOT_EN
   logic        redirect_pending_q, redirect_pending_d;
   logic [31:0] redirect_target_q, redirect_target_d;
`endif

   logic [31:0] p4;
   logic [31:0] jump_addr;
   logic [31:0] branch_addr;
   logic [31:0] flush_addr;
   logic [31:0] redirect_addr;
   logic        redirect;

   always_comb begin
      p4            = inst_pc_q + 32'd4;
      jump_addr     = {p4[31:28], jump_target, 2'b00};
      branch_addr   = p4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
      flush_addr    = {flush_pc[31:2], 2'b00};
      // jump wins over a simultaneously asserted branch
      redirect      = jump | (branch & branch_taken);
      redirect_addr = jump ? jump_addr : branch_addr;
   end

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the case infers a latch.
      state_d         = state_q;
      pc_d            = pc_q;
      inst_d          = inst_q;
      inst_pc_d       = inst_pc_q;
      inst_valid_d    = inst_valid_q;
      flush_pending_d = flush_pending_q;
      flush_target_d  = flush_target_q;
`ifdef DELAY_SLOT_EN
      redirect_pending_d = redirect_pending_q;
      redirect_target_d  = redirect_target_q;
`endif

      case (state_q)
         S_BOOT: begin
            state_d = S_FETCH;
         end

         S_FETCH: begin
            if (flush) begin
`ifdef DELAY_SLOT_EN
               redirect_pending_d = 1'b0;
`endif
               if (imem_ready) begin
                  pc_d            = flush_addr;
                  flush_pending_d = 1'b0;
               end else begin
                  // the outstanding request must complete before the restart
                  flush_pending_d = 1'b1;
                  flush_target_d  = flush_addr;
               end
            end else if (imem_ready) begin
               if (flush_pending_q) begin
                  pc_d            = flush_target_q;
                  flush_pending_d = 1'b0;
               end else begin
                  inst_d       = imem_rdata;
                  inst_pc_d    = pc_q;
                  inst_valid_d = 1'b1;
                  state_d      = S_ISSUE;
               end
            end
         end

         S_ISSUE: begin
            if (flush) begin
               pc_d            = flush_addr;
               inst_valid_d    = 1'b0;
               flush_pending_d = 1'b0;
               state_d         = S_FETCH;
`ifdef DELAY_SLOT_EN
               redirect_pending_d = 1'b0;
`endif
            end else if (!stall) begin
               inst_valid_d = 1'b0;
               state_d      = S_FETCH;
`ifdef DELAY_SLOT_EN
               // the delay-slot instruction's own redirect inputs are ignored
               if (redirect_pending_q) begin
                  pc_d               = redirect_target_q;
                  redirect_pending_d = 1'b0;
               end else begin
                  pc_d = p4;
                  if (redirect) begin
                     redirect_pending_d = 1'b1;
                     redirect_target_d  = redirect_addr;
                  end
               end
`else
               pc_d = redirect ? redirect_addr : p4;
`endif
            end
         end

         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= S_BOOT;
         pc_q            <= RESET_PC;
         inst_q          <= 32'd0;
         inst_pc_q       <= 32'd0;
         inst_valid_q    <= 1'b0;
         flush_pending_q <= 1'b0;
         flush_target_q  <= 32'd0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         inst_q          <= inst_d;
         inst_pc_q       <= inst_pc_d;
         inst_valid_q    <= inst_valid_d;
         flush_pending_q <= flush_pending_d;
         flush_target_q  <= flush_target_d;
      end
   end

`ifdef DELAY_SLOT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         redirect_pending_q <= 1'b0;
         redirect_target_q  <= 32'd0;
      end else begin
         redirect_pending_q <= redirect_pending_d;
         redirect_target_q  <= redirect_target_d;
      end
   end
`endif

   assign imem_req   = (state_q == S_FETCH);
   assign imem_addr  = pc_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_valid = inst_valid_q;
   assign pc         = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: issue-order scoreboard plus a next-PC vector table and corner sequences.
module tb_fetch_sequencer;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam logic [31:0] MAGIC  = 32'h5A5A_0F0F;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        jump;
   logic [25:0] jump_target;
   logic        branch;
   logic        branch_taken;
   logic [15:0] branch_imm;
   logic        flush;
   logic [31:0] flush_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic [31:0] pc;

   fetch_sequencer #(.RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .jump         (jump),
      .jump_target  (jump_target),
      .branch       (branch),
      .branch_taken (branch_taken),
      .branch_imm   (branch_imm),
      .flush        (flush),
      .flush_pc     (flush_pc),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .inst_valid   (inst_valid),
      .pc           (pc)
   );

   // memory model: each word is its own address scrambled with a constant
   assign imem_rdata = imem_addr ^ MAGIC;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // scoreboard: every newly issued instruction must match the oldest expected address
   logic        prev_valid;
   logic [31:0] mon_e;
   always @(negedge clk) begin
      if (reset) begin
         prev_valid = 1'b0;
      end else begin
         if (inst_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue: got inst_pc %h, expected no issue", inst_pc);
            end else begin
               mon_e = exp_q.pop_front();
               check("issue_pc", inst_pc, mon_e);
               check("issue_inst", inst, mon_e ^ MAGIC);
            end
         end
         prev_valid = inst_valid;
      end
   end

   typedef struct {
      logic [31:0] pc;
      logic        jump;
      logic [25:0] jt;
      logic        branch;
      logic        taken;
      logic [15:0] imm;
      logic [31:0] next;
   } vec_t;

   vec_t        vecs[8];
   logic [31:0] nxt;
   logic [31:0] held_inst;

   initial begin
      vecs[0] = '{32'h0040_0008, 1'b1, 26'h010_0040, 1'b1, 1'b1, 16'h0005, 32'h0040_0100};
      vecs[1] = '{32'h0040_0010, 1'b0, 26'h0,        1'b1, 1'b1, 16'hFFFF, 32'h0040_0010};
      vecs[2] = '{32'h0040_0010, 1'b0, 26'h0,        1'b1, 1'b0, 16'hFFFF, 32'h0040_0014};
      vecs[3] = '{32'hFFFF_FFFC, 1'b0, 26'h0,        1'b0, 1'b0, 16'h0000, 32'h0000_0000};
      vecs[4] = '{32'h0040_0010, 1'b0, 26'h0,        1'b1, 1'b1, 16'h0010, 32'h0040_0054};
      vecs[5] = '{32'hF000_1000, 1'b1, 26'h3FF_FFFF, 1'b0, 1'b0, 16'h0000, 32'hFFFF_FFFC};
      vecs[6] = '{32'h0040_0020, 1'b0, 26'h0,        1'b0, 1'b1, 16'h0040, 32'h0040_0024};
      vecs[7] = '{32'h1000_0000, 1'b0, 26'h0,        1'b1, 1'b1, 16'h8000, 32'h0FFE_0004};

      reset = 1'b1; stall = 1'b0; jump = 1'b0; jump_target = '0; branch = 1'b0;
      branch_taken = 1'b0; branch_imm = '0; flush = 1'b0; flush_pc = '0; imem_ready = 1'b1;

      // reset state and boot sequence
      repeat (2) @(negedge clk);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, RST_PC);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_pc", pc, RST_PC);
      reset = 1'b0;
      @(negedge clk);
      check("boot_req1", 32'(imem_req), 32'd1);
      check("boot_addr1", imem_addr, RST_PC);
      exp_q.push_back(RST_PC);
      @(negedge clk);
      check("boot_issue_req", 32'(imem_req), 32'd0);
      @(negedge clk);
      check("boot_addr2", imem_addr, RST_PC + 32'd4);
      exp_q.push_back(RST_PC + 32'd4);
      @(negedge clk);
      @(negedge clk);
      check("boot_addr3", imem_addr, RST_PC + 32'd8);
      exp_q.push_back(RST_PC + 32'd8);
      @(negedge clk);

      // stall for three cycles; redirect inputs during stall are ignored
      held_inst = inst;
      stall = 1'b1; jump = 1'b1; jump_target = 26'h3FF_0000; branch = 1'b1; branch_taken = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_valid", 32'(inst_valid), 32'd1);
         check("stall_inst_pc", inst_pc, RST_PC + 32'd8);
         check("stall_inst", inst, held_inst);
         check("stall_req", 32'(imem_req), 32'd0);
      end
      stall = 1'b0; jump = 1'b0; branch = 1'b0; branch_taken = 1'b0;
      @(negedge clk);
      check("resume_req", 32'(imem_req), 32'd1);
      check("resume_addr", imem_addr, RST_PC + 32'd12);
      exp_q.push_back(RST_PC + 32'd12);
      stall = 1'b1;
      @(negedge clk);

      // next-PC vector table, each entry entered via a flush while held in ISSUE
      for (int i = 0; i < 8; i++) begin
         flush = 1'b1; flush_pc = vecs[i].pc;
         exp_q.push_back(vecs[i].pc);
         @(negedge clk);
         flush = 1'b0;
         check("vec_fetch_addr", imem_addr, vecs[i].pc);
         @(negedge clk);
         stall = 1'b0; jump = vecs[i].jump; jump_target = vecs[i].jt;
         branch = vecs[i].branch; branch_taken = vecs[i].taken; branch_imm = vecs[i].imm;
         @(negedge clk);
`ifdef DELAY_SLOT_EN
         nxt = vecs[i].pc + 32'd4;
`else
         nxt = vecs[i].next;
`endif
         check("vec_next_addr", imem_addr, nxt);
         check("vec_next_req", 32'(imem_req), 32'd1);
         jump = 1'b0; branch = 1'b0; branch_taken = 1'b0; stall = 1'b1;
         exp_q.push_back(nxt);
         @(negedge clk);
      end

      // flush arriving in the same cycle as ready: data discarded, restart immediately
      flush = 1'b1; flush_pc = 32'h0040_0200;
      exp_q.push_back(32'h0040_0200);
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
      stall = 1'b0;
      @(negedge clk);
      check("fr_addr", imem_addr, 32'h0040_0204);
      flush = 1'b1; flush_pc = 32'h0040_0302;
      exp_q.push_back(32'h0040_0300);
      @(negedge clk);
      flush = 1'b0; stall = 1'b1;
      check("fr_restart_addr", imem_addr, 32'h0040_0300);
      check("fr_valid", 32'(inst_valid), 32'd0);
      @(negedge clk);

      // flush while ready is low: request held, target overwritten, data dropped
      imem_ready = 1'b0; flush = 1'b1; flush_pc = 32'h0040_0020;
      @(negedge clk);
      check("fp_addr1", imem_addr, 32'h0040_0020);
      check("fp_req1", 32'(imem_req), 32'd1);
      flush_pc = 32'h1111_1110;
      @(negedge clk);
      check("fp_addr2", imem_addr, 32'h0040_0020);
      flush_pc = 32'h8000_0183;
      @(negedge clk);
      flush = 1'b0;
      check("fp_addr3", imem_addr, 32'h0040_0020);
      check("fp_req3", 32'(imem_req), 32'd1);
      @(negedge clk);
      check("fp_addr4", imem_addr, 32'h0040_0020);
      imem_ready = 1'b1;
      @(negedge clk);
      check("fp_target_addr", imem_addr, 32'h8000_0180);
      check("fp_target_req", 32'(imem_req), 32'd1);
      check("fp_valid", 32'(inst_valid), 32'd0);
      exp_q.push_back(32'h8000_0180);
      @(negedge clk);

      // asynchronous reset in the middle of a fetch
      stall = 1'b0; imem_ready = 1'b0;
      @(negedge clk);
      check("rf_addr", imem_addr, 32'h8000_0184);
      #2 reset = 1'b1;
      #1;
      check("rf_req_drop", 32'(imem_req), 32'd0);
      check("rf_addr_rst", imem_addr, RST_PC);
      check("rf_valid", 32'(inst_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0; imem_ready = 1'b1;
      check("rf_boot_req", 32'(imem_req), 32'd0);
      @(negedge clk);
      check("rf_refetch_addr", imem_addr, RST_PC);
      check("rf_refetch_req", 32'(imem_req), 32'd1);
      exp_q.push_back(RST_PC);
      stall = 1'b1;
      @(negedge clk);

      // taken branch at 0x100 targeting 0x200: issue order depends on delay-slot mode
      flush = 1'b1; flush_pc = 32'h0000_0100;
      exp_q.push_back(32'h0000_0100);
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
      stall = 1'b0; branch = 1'b1; branch_taken = 1'b1; branch_imm = 16'h003F;
`ifdef DELAY_SLOT_EN
      exp_q.push_back(32'h0000_0104);
      exp_q.push_back(32'h0000_0200);
`else
      exp_q.push_back(32'h0000_0200);
      exp_q.push_back(32'h0000_0204);
`endif
      @(negedge clk);
      branch = 1'b0; branch_taken = 1'b0;
      @(negedge clk);
      @(negedge clk);
      stall = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
